dmem_bridge: RTL and testbench

//  Data-side bus bridge between the pipelined core and memory/IO. Generalises the fixed two-RAM data path
//  to NUM_BANKS word-wide RAM banks plus one IO region. Adds a req/ready/rsp handshake, sized access
//  (byte/half/word), byte-lane steering, load extraction with sign extension, and misalign/decode errors.

---
 rtl/dmem_bridge_pkg.sv | 49 ++++
 rtl/dmem_load_align.sv | 26 ++
 rtl/dmem_bridge.sv | 191 +++++++++++++++++++
 tb/tb_dmem_bridge.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared types and helpers for the data-side bus bridge: FSM states, access sizes,
// address regions, and the byte-lane helpers used on the store path and in decode.
package dmem_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RAM_RSP,
      ST_IO_WAIT,
      ST_IO_RSP,
      ST_ERR_RSP
   } state_t;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_IO,
      REG_NONE
   } region_t;

   // Size 3 is treated as misaligned so every illegal access takes a single error path.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_B:  return 1'b0;
         SIZE_H:  return off[0];
         SIZE_W:  return off != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_B:  return 4'b0001 << off;
         SIZE_H:  return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] steer_data(input logic [1:0] size, input logic [31:0] d);
      case (size)
         SIZE_B:  return {4{d[7:0]}};
         SIZE_H:  return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load extraction: selects the addressed byte/half lane from a 32-bit read word and
// zero- or sign-extends it. Purely combinational; shared by the RAM and IO return paths.
module dmem_load_align
   import dmem_bridge_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        is_signed,
   output logic [31:0] data
);

   logic [31:0] shifted;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
      shifted = rdata >> {off, 3'b000};
      data    = rdata;
      case (size)
         SIZE_B:  data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
         SIZE_H:  data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/dmem_bridge.sv
// Data-side bridge from the core's req/ready/rsp port to NUM_BANKS word-wide RAM banks
// and one IO region. Optional IO watchdog enabled by defining DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bridge
   import dmem_bridge_pkg::*;
#(
   parameter int          NUM_BANKS  = 2,
   parameter int          BANK_AW    = 14,
   parameter logic [31:0] IO_BASE    = 32'h8000_0000,
   parameter int          IO_AW      = 8,
   parameter int          IO_TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     resetb,
   input  logic                     dm_req,
   output logic                     dm_ready,
   input  logic                     dm_we,
   input  logic [31:0]              dm_addr,
   input  logic [1:0]               dm_size,
   input  logic                     dm_is_signed,
   input  logic [31:0]              dm_di,
   output logic                     dm_rsp,
   output logic [31:0]              dm_do,
   output logic                     dm_err,
   output logic [BANK_AW-1:0]       ram_addr,
   output logic [31:0]              ram_di,
   output logic [3:0]               ram_be,
   output logic [NUM_BANKS-1:0]     ram_we,
   input  logic [32*NUM_BANKS-1:0]  ram_do,
   output logic [IO_AW-1:0]         io_addr,
   output logic                     io_en,
   output logic                     io_we,
   output logic [31:0]              io_data_write,
   input  logic [31:0]              io_data_read,
   input  logic                     io_ready
);

   localparam int BANK_BITS    = $clog2(NUM_BANKS);
   localparam int BANK_SEL_W   = (BANK_BITS > 0) ? BANK_BITS : 1;
   localparam int RAM_SPAN_LSB = BANK_AW + 2 + BANK_BITS;

   state_t                state_q, state_d;
   region_t               region;
   logic                  accept;
   logic                  ram_hit, io_hit;
   logic [BANK_SEL_W-1:0] bank_idx;

   logic [1:0]            lat_off;
   logic [1:0]            lat_size;
   logic                  lat_signed;
   logic                  lat_we;
   logic [BANK_SEL_W-1:0] lat_bank;
   logic [31:0]           io_rdata_q;
   logic                  io_err_q;
   logic                  timeout;

   logic [31:0]           ram_words [NUM_BANKS];
   logic [31:0]           align_src;
   logic [31:0]           aligned;

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank_split
      assign ram_words[g] = ram_do[g*32 +: 32];
   end

   // Decode: RAM occupies [0, NUM_BANKS*bank_size); IO is the 2^IO_AW window at IO_BASE.
   assign ram_hit  = (dm_addr >> RAM_SPAN_LSB) == 32'd0;
   assign io_hit   = (dm_addr >> IO_AW) == (IO_BASE >> IO_AW);
   assign bank_idx = BANK_SEL_W'((dm_addr >> (BANK_AW + 2)) & 32'(NUM_BANKS - 1));

   always_comb begin
      region = REG_NONE;
      if (!misaligned(dm_size, dm_addr[1:0])) begin
         if (ram_hit)     region = REG_RAM;
         else if (io_hit) region = REG_IO;
      end
   end

   assign dm_ready = (state_q == ST_IDLE) || (state_q == ST_RAM_RSP) || (state_q == ST_ERR_RSP);
   assign accept   = dm_req && dm_ready;

   // RAM port is driven straight from the request so the bank sees the access in the accept cycle.
   assign ram_addr = dm_addr[BANK_AW+1:2];
   assign ram_be   = lane_mask(dm_size, dm_addr[1:0]);
   assign ram_di   = steer_data(dm_size, dm_di);

   always_comb begin
      ram_we = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         ram_we[i] = accept && (region == REG_RAM) && dm_we && (bank_idx == BANK_SEL_W'(i));
      end
   end

`ifdef DMEM_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(IO_TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q;

   assign timeout = (cnt_q == CNT_W'(IO_TIMEOUT));

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         cnt_q <= '0;
      end else if (accept && (region == REG_IO)) begin
         cnt_q <= '0;
      end else if ((state_q == ST_IO_WAIT) && !io_ready && !timeout) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_RAM_RSP, ST_ERR_RSP: begin
            state_d = ST_IDLE;
            if (accept) begin
               case (region)
                  REG_RAM: state_d = ST_RAM_RSP;
                  REG_IO:  state_d = ST_IO_WAIT;
                  default: state_d = ST_ERR_RSP;
               endcase
            end
         end
         ST_IO_WAIT: if (io_ready || timeout) state_d = ST_IO_RSP;
         ST_IO_RSP:  state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
         state_q       <= ST_IDLE;
         lat_off       <= 2'b00;
         lat_size      <= SIZE_B;
         lat_signed    <= 1'b0;
         lat_we        <= 1'b0;
         lat_bank      <= '0;
         io_en         <= 1'b0;
         io_we         <= 1'b0;
         io_addr       <= '0;
         io_data_write <= '0;
         io_rdata_q    <= '0;
         io_err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            lat_off    <= dm_addr[1:0];
            lat_size   <= dm_size;
            lat_signed <= dm_is_signed;
            lat_we     <= dm_we;
            lat_bank   <= bank_idx;
         end
         if (accept && (region == REG_IO)) begin
            io_en         <= 1'b1;
            io_we         <= dm_we;
            io_addr       <= dm_addr[IO_AW-1:0];
            io_data_write <= steer_data(dm_size, dm_di);
            io_err_q      <= 1'b0;
         end else if (state_q == ST_IO_WAIT) begin
            if (io_ready) begin
               io_en      <= 1'b0;
               io_we      <= 1'b0;
               io_rdata_q <= io_data_read;
            end else if (timeout) begin
               io_en      <= 1'b0;
               io_we      <= 1'b0;
               io_rdata_q <= '0;
               io_err_q   <= 1'b1;
            end
         end
      end
   end

   // RAM data arrives registered by the bank, so it is aligned live in RAM_RSP; IO data was captured.
   assign align_src = (state_q == ST_RAM_RSP) ? ram_words[lat_bank] : io_rdata_q;

   dmem_load_align u_align (
      .rdata     (align_src),
      .off       (lat_off),
      .size      (lat_size),
      .is_signed (lat_signed),
      .data      (aligned)
   );

   assign dm_rsp = (state_q == ST_RAM_RSP) || (state_q == ST_IO_RSP) || (state_q == ST_ERR_RSP);
   assign dm_err = (state_q == ST_ERR_RSP) || ((state_q == ST_IO_RSP) && io_err_q);
   assign dm_do  = (((state_q == ST_RAM_RSP) || ((state_q == ST_IO_RSP) && !io_err_q)) && !lat_we)
                   ? aligned : 32'd0;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: byte-level memory reference model, directed spec
// cases, error decode, IO handshake, back-to-back RAM traffic, timeout and reset abort.
module tb_dmem_bridge;
   import dmem_bridge_pkg::*;

   localparam int          NB    = 2;
   localparam int          BAW   = 14;
   localparam int          IOAW  = 8;
   localparam int          IO_TO = 255;
   localparam logic [31:0] IOB   = 32'h8000_0000;
   localparam logic [31:0] RAM_END = 32'h0002_0000;

   logic              clk = 1'b0;
   logic              resetb = 1'b0;
   logic              dm_req = 1'b0;
   logic              dm_we = 1'b0;
   logic [31:0]       dm_addr = '0;
   logic [1:0]        dm_size = '0;
   logic              dm_is_signed = 1'b0;
   logic [31:0]       dm_di = '0;
   logic              dm_ready, dm_rsp, dm_err;
   logic [31:0]       dm_do;
   logic [BAW-1:0]    ram_addr;
   logic [31:0]       ram_di;
   logic [3:0]        ram_be;
   logic [NB-1:0]     ram_we;
   logic [32*NB-1:0]  ram_do;
   logic [IOAW-1:0]   io_addr;
   logic              io_en, io_we;
   logic [31:0]       io_data_write;
   logic [31:0]       io_data_read = '0;
   logic              io_ready = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dmem_bridge #(.NUM_BANKS(NB), .BANK_AW(BAW), .IO_BASE(IOB), .IO_AW(IOAW), .IO_TIMEOUT(IO_TO)) dut (
      .clk(clk), .resetb(resetb),
      .dm_req(dm_req), .dm_ready(dm_ready), .dm_we(dm_we), .dm_addr(dm_addr), .dm_size(dm_size),
      .dm_is_signed(dm_is_signed), .dm_di(dm_di), .dm_rsp(dm_rsp), .dm_do(dm_do), .dm_err(dm_err),
      .ram_addr(ram_addr), .ram_di(ram_di), .ram_be(ram_be), .ram_we(ram_we), .ram_do(ram_do),
      .io_addr(io_addr), .io_en(io_en), .io_we(io_we), .io_data_write(io_data_write),
      .io_data_read(io_data_read), .io_ready(io_ready)
   );

   // Block RAM environment: registered read (read-before-write), byte-enabled write.
   bit [31:0] ram_mem [NB][2**BAW];
   bit [31:0] rd_q [NB];
   assign ram_do = {rd_q[1], rd_q[0]};

   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         rd_q[b] <= ram_mem[b][ram_addr];
         if (ram_we[b])
            for (int l = 0; l < 4; l++)
               if (ram_be[l]) ram_mem[b][ram_addr][8*l +: 8] <= ram_di[8*l +: 8];
      end
   end

   // Reference model: flat byte-addressed memory.
   bit [7:0] ref_bytes [bit [31:0]];

   function automatic int nbytes(input logic [1:0] s);
      return 1 << s;
   endfunction

   function automatic bit [7:0] ref_byte(input bit [31:0] a);
      if (ref_bytes.exists(a)) return ref_bytes[a];
      return 8'h00;
   endfunction

   function automatic void ref_store(input bit [31:0] a, input logic [1:0] s, input logic [31:0] d);
      for (int k = 0; k < nbytes(s); k++) ref_bytes[a + k] = d[8*k +: 8];
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] v, input int n, input bit sgn);
      if (n < 4 && sgn && v[8*n-1]) return v | (32'hFFFF_FFFF << (8*n));
      return v;
   endfunction

   function automatic logic [31:0] ref_load(input bit [31:0] a, input logic [1:0] s, input bit sgn);
      logic [31:0] v = '0;
      for (int k = 0; k < nbytes(s); k++) v |= 32'(ref_byte(a + k)) << (8*k);
      return extend(v, nbytes(s), sgn);
   endfunction

   function automatic logic [31:0] io_extract(input logic [31:0] w, input logic [31:0] a,
                                              input logic [1:0] s, input bit sgn);
      logic [31:0] v = '0;
      int off = int'(a[1:0]);
      for (int k = 0; k < nbytes(s); k++) v |= 32'(w[8*(off+k) +: 8]) << (8*k);
      return extend(v, nbytes(s), sgn);
   endfunction

   function automatic logic [31:0] exp_steer(input logic [31:0] d, input logic [1:0] s);
      logic [31:0] w;
      for (int l = 0; l < 4; l++) w[8*l +: 8] = d[8*(l % nbytes(s)) +: 8];
      return w;
   endfunction

   function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] s);
      logic [3:0] be = '0;
      for (int k = 0; k < nbytes(s); k++) be[int'(a[1:0]) + k] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] rand_ram_addr(input logic [1:0] s);
      logic [31:0] a = ($urandom_range(0, 1) << 16) | ($urandom_range(0, 31) << 2);
      if (s == SIZE_B) a[1:0] = 2'($urandom_range(0, 3));
      if (s == SIZE_H) a[1]   = 1'($urandom_range(0, 1));
      return a;
   endfunction

   // Results of the last single access.
   bit           r_rsp, r_err, r_ready_hi;
   logic [31:0]  r_do;
   int           r_lat, r_io_cycles;
   logic [NB-1:0] acc_ram_we;
   logic [3:0]   acc_ram_be;
   logic [31:0]  acc_ram_di;
   logic [BAW-1:0] acc_ram_addr;
   logic [IOAW-1:0] io_seen_addr;
   logic         io_seen_we;
   logic [31:0]  io_seen_wdata;

   // One request; io_delay = io_en cycles before io_ready is raised (-1 = never).
   task automatic access(input bit we, input logic [31:0] addr, input logic [1:0] size, input bit sgn,
                         input logic [31:0] di, input int io_delay, input logic [31:0] io_word);
      @(negedge clk);
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_size = size; dm_is_signed = sgn; dm_di = di;
      #1;
      acc_ram_we = ram_we; acc_ram_be = ram_be; acc_ram_di = ram_di; acc_ram_addr = ram_addr;
      @(posedge clk);
      #1;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = $urandom; dm_di = $urandom; dm_size = 2'($urandom);
      r_rsp = 0; r_err = 0; r_do = 'x; r_lat = 0; r_io_cycles = 0; r_ready_hi = 0;
      for (int c = 1; c <= 400 && !r_rsp; c++) begin
         @(negedge clk);
         io_ready = 1'b0;
         if (dm_ready) r_ready_hi = 1;
         if (dm_rsp) begin
            r_rsp = 1; r_do = dm_do; r_err = dm_err; r_lat = c;
         end else if (io_en) begin
            r_io_cycles++;
            if (r_io_cycles == 1) begin
               io_seen_addr = io_addr; io_seen_we = io_we; io_seen_wdata = io_data_write;
            end
            if (r_io_cycles == io_delay) begin
               io_ready = 1'b1; io_data_read = io_word;
            end
         end
      end
      if (r_rsp && !r_err && we && addr < RAM_END) ref_store(addr, size, di);
   endtask

   task automatic test_reset;
      resetb = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (dm_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", dm_ready); end
      checks++; if ({dm_rsp, dm_err, io_en, io_we} !== 4'b0) begin
         errors++; $display("FAIL reset_ctl: rsp/err/io_en/io_we got %b want 0000", {dm_rsp, dm_err, io_en, io_we});
      end
      checks++; if (dm_do !== 32'd0) begin errors++; $display("FAIL reset_do: got %h want 0", dm_do); end
      checks++; if (ram_we !== '0) begin errors++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
      resetb = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ram_directed;
      access(1, 32'h0000_0010, SIZE_W, 0, 32'hDEAD_BEEF, 0, '0);
      access(0, 32'h0000_0010, SIZE_W, 0, '0, 0, '0);
      checks++; if (acc_ram_addr !== 14'd4 || acc_ram_we !== 2'b00) begin
         errors++; $display("FAIL lw_strobes: addr=%0d we=%b want 4/00", acc_ram_addr, acc_ram_we);
      end
      checks++; if (r_lat !== 1 || r_err !== 1'b0 || r_do !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL lw_data: lat=%0d err=%b do=%h want 1/0/deadbeef", r_lat, r_err, r_do);
      end
      access(1, 32'h0001_0003, SIZE_B, 0, 32'h0000_00A5, 0, '0);
      checks++; if (acc_ram_we !== 2'b10 || acc_ram_be !== 4'b1000 || acc_ram_di !== 32'hA5A5_A5A5) begin
         errors++; $display("FAIL sb_steer: we=%b be=%b di=%h want 10/1000/a5a5a5a5", acc_ram_we, acc_ram_be, acc_ram_di);
      end
      checks++; if (r_lat !== 1 || r_do !== 32'd0 || r_err !== 1'b0) begin
         errors++; $display("FAIL sb_rsp: lat=%0d do=%h err=%b want 1/0/0", r_lat, r_do, r_err);
      end
      access(1, 32'h0000_0000, SIZE_W, 0, 32'h0000_8000, 0, '0);
      access(0, 32'h0000_0001, SIZE_B, 1, '0, 0, '0);
      checks++; if (r_do !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed: got %h want ffffff80", r_do); end
      access(0, 32'h0000_0001, SIZE_B, 0, '0, 0, '0);
      checks++; if (r_do !== 32'h0000_0080) begin errors++; $display("FAIL lbu: got %h want 00000080", r_do); end
      access(0, 32'h0000_0002, SIZE_H, 1, '0, 0, '0);
      checks++; if (r_do !== 32'h0000_0000) begin errors++; $display("FAIL lh_upper: got %h want 0", r_do); end
      // Last word of the last bank.
      access(1, 32'h0001_FFFC, SIZE_W, 0, 32'hCAFE_F00D, 0, '0);
      checks++; if (acc_ram_we !== 2'b10 || acc_ram_addr !== 14'h3FFF) begin
         errors++; $display("FAIL top_word_strobe: we=%b addr=%h want 10/3fff", acc_ram_we, acc_ram_addr);
      end
      access(0, 32'h0001_FFFE, SIZE_H, 1, '0, 0, '0);
      checks++; if (r_do !== 32'hFFFF_CAFE) begin errors++; $display("FAIL top_word_lh: got %h want ffffcafe", r_do); end
   endtask

   task automatic test_errors;
      logic [31:0] addrs [6] = '{32'h0000_0001, 32'h4000_0000, 32'h0000_0002, 32'h0000_0000,
                                 32'h0002_0000, 32'h8000_0100};
      logic [1:0]  sizes [6] = '{SIZE_H, SIZE_W, SIZE_W, 2'd3, SIZE_B, SIZE_B};
      bit          wes   [6] = '{0, 0, 1, 0, 1, 0};
      for (int i = 0; i < 6; i++) begin
         access(wes[i], addrs[i], sizes[i], 0, 32'hFFFF_FFFF, 1, 32'h1111_1111);
         checks++; if (acc_ram_we !== '0 || r_io_cycles !== 0) begin
            errors++; $display("FAIL err%0d_strobe: ram_we=%b io_cycles=%0d want 0/0", i, acc_ram_we, r_io_cycles);
         end
         checks++; if (r_lat !== 1 || r_err !== 1'b1 || r_do !== 32'd0) begin
            errors++; $display("FAIL err%0d_rsp: lat=%0d err=%b do=%h want 1/1/0", i, r_lat, r_err, r_do);
         end
      end
      access(0, 32'h0000_0000, SIZE_W, 0, '0, 0, '0);
      checks++; if (r_do !== 32'h0000_8000) begin errors++; $display("FAIL err_no_write: got %h want 00008000", r_do); end
   endtask

   task automatic test_io;
      int seen;
      access(0, 32'h8000_0004, SIZE_W, 0, '0, 3, 32'h1234_5678);
      checks++; if (r_io_cycles !== 3 || r_ready_hi !== 1'b0) begin
         errors++; $display("FAIL io_lw_hs: io_en cycles=%0d ready_hi=%b want 3/0", r_io_cycles, r_ready_hi);
      end
      checks++; if (r_lat !== 4 || r_err !== 1'b0 || r_do !== 32'h1234_5678 || io_seen_addr !== 8'h04) begin
         errors++; $display("FAIL io_lw_rsp: lat=%0d err=%b do=%h addr=%h want 4/0/12345678/04", r_lat, r_err, r_do, io_seen_addr);
      end
      for (int i = 0; i < 12; i++) begin
         bit          we    = 1'($urandom_range(0, 1));
         bit          sgn   = 1'($urandom_range(0, 1));
         logic [1:0]  s     = 2'($urandom_range(0, 2));
         logic [31:0] a     = IOB | ($urandom_range(0, 63) << 2);
         logic [31:0] di    = $urandom;
         logic [31:0] word  = $urandom;
         int          delay = $urandom_range(1, 6);
         if (s == SIZE_B) a[1:0] = 2'($urandom_range(0, 3));
         if (s == SIZE_H) a[1]   = 1'($urandom_range(0, 1));
         access(we, a, s, sgn, di, delay, word);
         checks++; if (io_seen_addr !== a[7:0] || io_seen_we !== we || r_io_cycles !== delay || r_ready_hi !== 1'b0) begin
            errors++; $display("FAIL io_rand%0d_hs: addr=%h we=%b cyc=%0d rdy=%b want %h/%b/%0d/0",
                               i, io_seen_addr, io_seen_we, r_io_cycles, r_ready_hi, a[7:0], we, delay);
         end
         if (we) begin
            checks++; if (io_seen_wdata !== exp_steer(di, s)) begin
               errors++; $display("FAIL io_rand%0d_wdata: got %h want %h", i, io_seen_wdata, exp_steer(di, s));
            end
         end
         checks++; if (!r_rsp || r_err !== 1'b0 || r_do !== (we ? 32'd0 : io_extract(word, a, s, sgn))) begin
            errors++; $display("FAIL io_rand%0d_rsp: rsp=%b err=%b do=%h want 1/0/%h",
                               i, r_rsp, r_err, r_do, we ? 32'd0 : io_extract(word, a, s, sgn));
         end
      end
      // Stray io_ready while idle must be ignored.
      seen = 0;
      @(negedge clk); io_ready = 1'b1;
      repeat (3) begin @(negedge clk); if (dm_rsp || io_en) seen++; end
      io_ready = 1'b0;
      checks++; if (seen !== 0) begin errors++; $display("FAIL io_ready_idle: activity cycles=%0d want 0", seen); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp_q [$];
      logic [31:0] want;
      int          n_err = 0;
      @(negedge clk);
      for (int i = 0; i <= 40; i++) begin
         if (dm_ready !== 1'b1) n_err++;
         if (i > 0) begin
            want = exp_q.pop_front();
            checks++; if (dm_rsp !== 1'b1 || dm_err !== 1'b0 || dm_do !== want) begin
               errors++; $display("FAIL b2b%0d: rsp=%b err=%b do=%h want 1/0/%h", i - 1, dm_rsp, dm_err, dm_do, want);
            end
         end
         if (i < 40) begin
            bit          we  = 1'($urandom_range(0, 1));
            bit          sgn = 1'($urandom_range(0, 1));
            logic [1:0]  s   = 2'($urandom_range(0, 2));
            logic [31:0] a   = rand_ram_addr(s);
            logic [31:0] di  = $urandom;
            dm_req = 1'b1; dm_we = we; dm_addr = a; dm_size = s; dm_is_signed = sgn; dm_di = di;
            if (we) begin
               ref_store(a, s, di);
               exp_q.push_back(32'd0);
            end else begin
               exp_q.push_back(ref_load(a, s, sgn));
            end
            #1;
            checks++; if (ram_be !== exp_be(a, s)) begin
               errors++; $display("FAIL b2b%0d_be: got %b want %b", i, ram_be, exp_be(a, s));
            end
         end else begin
            dm_req = 1'b0;
         end
         @(negedge clk);
      end
      checks++; if (n_err !== 0 || dm_rsp !== 1'b0) begin
         errors++; $display("FAIL b2b_ready: not-ready cycles=%0d trailing rsp=%b want 0/0", n_err, dm_rsp);
      end
   endtask

   task automatic test_timeout_abort;
      int seen;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      access(0, 32'h8000_0010, SIZE_W, 0, '0, -1, '0);
      checks++; if (!r_rsp || r_err !== 1'b1 || r_do !== 32'd0) begin
         errors++; $display("FAIL timeout_rsp: rsp=%b err=%b do=%h want 1/1/0", r_rsp, r_err, r_do);
      end
      checks++; if (r_io_cycles < IO_TO || r_io_cycles > IO_TO + 1) begin
         errors++; $display("FAIL timeout_len: io_en cycles=%0d want %0d..%0d", r_io_cycles, IO_TO, IO_TO + 1);
      end
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h8000_0020; dm_size = SIZE_W;
      @(posedge clk); #1; dm_req = 1'b0;
      repeat (10) @(negedge clk);
`else
      access(0, 32'h8000_0010, SIZE_W, 0, '0, -1, '0);
      checks++; if (r_rsp !== 1'b0 || r_io_cycles !== 400) begin
         errors++; $display("FAIL io_wait_forever: rsp=%b io_en cycles=%0d want 0/400", r_rsp, r_io_cycles);
      end
`endif
      checks++; if (io_en !== 1'b1 || dm_ready !== 1'b0) begin
         errors++; $display("FAIL abort_pre: io_en=%b ready=%b want 1/0", io_en, dm_ready);
      end
      resetb = 1'b0;
      #1;
      checks++; if (io_en !== 1'b0 || dm_rsp !== 1'b0 || dm_ready !== 1'b1) begin
         errors++; $display("FAIL abort_reset: io_en=%b rsp=%b ready=%b want 0/0/1", io_en, dm_rsp, dm_ready);
      end
      @(negedge clk); resetb = 1'b1;
      seen = 0;
      repeat (20) begin @(negedge clk); if (dm_rsp || io_en) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_rsp: activity cycles=%0d want 0", seen); end
      access(0, 32'h0000_0010, SIZE_W, 0, '0, 0, '0);
      checks++; if (r_do !== 32'hDEAD_BEEF || r_lat !== 1) begin
         errors++; $display("FAIL after_abort: do=%h lat=%0d want deadbeef/1", r_do, r_lat);
      end
   endtask

   initial begin
      test_reset();
      test_ram_directed();
      test_errors();
      test_io();
      test_back_to_back();
      test_timeout_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
